sprite_table_fetcher: RTL and testbench

//  Parametrised sprite-position fetcher for the VGA path. Once per frame it walks
//  a table of NUM_SPRITES (x,y) word pairs in data memory through the VGA-side RAM

---
 rtl/sprite_table_fetcher.sv | 180 ++++++++++++++++++
 tb/tb_sprite_table_fetcher.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_table_fetcher.sv
// sprite_table_fetcher
//   Once per frame, reads a table of NUM_SPRITES (x,y) word pairs from data
//   memory into a shadow bank. The whole bank is then copied to the position
//   outputs in a single cycle, so the renderer never sees a frame that is only
//   partly updated.
//
//   Word k of the table is at BASE_ADDR + k*STRIDE, wrapping mod 2^WIDTH.
//   Word 2i is the x of sprite i and word 2i+1 is the y of sprite i.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   frame_start    1-cycle pulse that starts a fetch
//   mem_addr       RAM read address
//   mem_rd         mem_addr is a live read this cycle
//   mem_data       RAM read data, valid RD_LATENCY cycles after mem_rd
//   sprite_x/y     committed positions, sprite i at [i*WIDTH +: WIDTH]
//   table_valid    sticky; set by the first commit after reset
//   busy           fetch in progress (ISSUE, DRAIN, COMMIT)
//   commit         high for the single COMMIT cycle
//   frame_overrun  1-cycle pulse after a frame_start that arrived while busy
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for frame_start, address parked at BASE_ADDR
// S_ISSUE  | one read per cycle for words 0 .. 2*NUM_SPRITES-1
// S_DRAIN  | no new reads; waiting for the last word to return
// S_COMMIT | shadow bank copied to the outputs on the closing edge
module sprite_table_fetcher #(
  parameter int          WIDTH       = 16,
  parameter int          NUM_SPRITES = 3,
  parameter int unsigned BASE_ADDR   = 6000,
  parameter int unsigned STRIDE      = 4,
  parameter int          RD_LATENCY  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_start,
  output logic [WIDTH-1:0]             mem_addr,
  output logic                         mem_rd,
  input  logic [WIDTH-1:0]             mem_data,
  output logic [NUM_SPRITES*WIDTH-1:0] sprite_x,
  output logic [NUM_SPRITES*WIDTH-1:0] sprite_y,
  output logic                         table_valid,
  output logic                         busy,
  output logic                         commit,
  output logic                         frame_overrun
);

  localparam int NW = 2 * NUM_SPRITES;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WIDTH-1:0] BASE     = WIDTH'(BASE_ADDR);
  localparam logic [WIDTH-1:0] STEP     = WIDTH'(STRIDE);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NW - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [WIDTH-1:0]             addr_q, addr_d;
  logic                         pipe_vld_q [RD_LATENCY];
  logic                         pipe_vld_d [RD_LATENCY];
  logic [IW-1:0]                pipe_idx_q [RD_LATENCY];
  logic [IW-1:0]                pipe_idx_d [RD_LATENCY];
  logic [WIDTH-1:0]             shadow_q   [NW];
  logic [WIDTH-1:0]             shadow_d   [NW];
  logic [NUM_SPRITES*WIDTH-1:0] sprite_x_q, sprite_x_d;
  logic [NUM_SPRITES*WIDTH-1:0] sprite_y_q, sprite_y_d;
  logic                         table_valid_q, table_valid_d;
  logic                         frame_overrun_q, frame_overrun_d;

  logic                         rd_now;
  logic                         cap_vld;
  logic [IW-1:0]                cap_idx;

  assign rd_now  = (state_q == S_ISSUE);
  assign cap_vld = pipe_vld_q[RD_LATENCY-1];
  assign cap_idx = pipe_idx_q[RD_LATENCY-1];

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    addr_d          = addr_q;
    shadow_d        = shadow_q;
    sprite_x_d      = sprite_x_q;
    sprite_y_d      = sprite_y_q;
    table_valid_d   = table_valid_q;
    frame_overrun_d = frame_start && (state_q != S_IDLE);

    // Each read carries its word index down the delay line so the returning
    // data lands in the right slot regardless of latency.
    pipe_vld_d[0] = rd_now;
    pipe_idx_d[0] = idx_q;
    for (int s = 1; s < RD_LATENCY; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_idx_d[s] = pipe_idx_q[s-1];
    end

    for (int j = 0; j < NW; j++) begin
      if (cap_vld && (cap_idx == IW'(j))) shadow_d[j] = mem_data;
    end

    unique case (state_q)
      S_IDLE: begin
        addr_d = BASE;
        idx_d  = '0;
        if (frame_start) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
          addr_d  = BASE;
          idx_d   = '0;
        end else begin
          addr_d = addr_q + STEP;
          idx_d  = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Words return in issue order, so the last index emerging means the
        // bank is complete once this cycle's capture lands.
        if (cap_vld && (cap_idx == LAST_IDX)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          sprite_x_d[i*WIDTH +: WIDTH] = shadow_q[2*i];
          sprite_y_d[i*WIDTH +: WIDTH] = shadow_q[2*i+1];
        end
        table_valid_d = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      addr_q          <= BASE;
      sprite_x_q      <= '0;
      sprite_y_q      <= '0;
      table_valid_q   <= 1'b0;
      frame_overrun_q <= 1'b0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_vld_q[s] <= 1'b0;
        pipe_idx_q[s] <= '0;
      end
      for (int j = 0; j < NW; j++) shadow_q[j] <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      addr_q          <= addr_d;
      sprite_x_q      <= sprite_x_d;
      sprite_y_q      <= sprite_y_d;
      table_valid_q   <= table_valid_d;
      frame_overrun_q <= frame_overrun_d;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_vld_q[s] <= pipe_vld_d[s];
        pipe_idx_q[s] <= pipe_idx_d[s];
      end
      for (int j = 0; j < NW; j++) shadow_q[j] <= shadow_d[j];
    end
  end

  assign mem_addr      = addr_q;
  assign mem_rd        = rd_now;
  assign sprite_x      = sprite_x_q;
  assign sprite_y      = sprite_y_q;
  assign table_valid   = table_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign commit        = (state_q == S_COMMIT);
  assign frame_overrun = frame_overrun_q;

endmodule

// File: tb/tb_sprite_table_fetcher.sv
`define CHK(tag, o, e) chk(tag, 128'(o), 128'(e))

module tb_sprite_table_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic frame_start, frame_start2;

  // Instance 1: default parameters, latency-1 RAM
  logic [15:0] mem_addr1, mem_data1;
  logic        mem_rd1;
  logic [47:0] sprite_x1, sprite_y1;
  logic        table_valid1, busy1, commit1, frame_overrun1;

  // Instance 2: 8 sprites, stride 2, wrapping base, latency-2 RAM
  logic [15:0]  mem_addr2, mem_data2;
  logic         mem_rd2;
  logic [127:0] sprite_x2, sprite_y2;
  logic         table_valid2, busy2, commit2, frame_overrun2;

  logic [15:0] ram [65536];

  logic        r1_rd = 1'b0;
  logic [15:0] r1_a  = '0;
  logic        r2a_rd = 1'b0, r2b_rd = 1'b0;
  logic [15:0] r2a_a = '0, r2b_a = '0;

  always @(posedge clk) begin
    r1_rd  <= mem_rd1;
    r1_a   <= mem_addr1;
    r2a_rd <= mem_rd2;
    r2a_a  <= mem_addr2;
    r2b_rd <= r2a_rd;
    r2b_a  <= r2a_a;
  end

  // Junk on the bus whenever no read is returning
  assign mem_data1 = r1_rd  ? ram[r1_a]  : 16'hDEAD;
  assign mem_data2 = r2b_rd ? ram[r2b_a] : 16'hBEEF;

  sprite_table_fetcher dut1 (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_data(mem_data1),
    .sprite_x(sprite_x1), .sprite_y(sprite_y1), .table_valid(table_valid1),
    .busy(busy1), .commit(commit1), .frame_overrun(frame_overrun1)
  );

  sprite_table_fetcher #(
    .WIDTH(16), .NUM_SPRITES(8), .BASE_ADDR(32'hFFF8), .STRIDE(2), .RD_LATENCY(2)
  ) dut2 (
    .clk(clk), .reset(reset), .frame_start(frame_start2),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_data(mem_data2),
    .sprite_x(sprite_x2), .sprite_y(sprite_y2), .table_valid(table_valid2),
    .busy(busy2), .commit(commit2), .frame_overrun(frame_overrun2)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_table1(input logic [15:0] w0, w1, w2, w3, w4, w5);
    ram[16'd6000] = w0; ram[16'd6004] = w1; ram[16'd6008] = w2;
    ram[16'd6012] = w3; ram[16'd6016] = w4; ram[16'd6020] = w5;
  endtask

  // Runs cycles 0..10 of one fetch on instance 1; frame_start at c0 plus
  // optional extra pulses at ova/ovb.
  task automatic fetch1(input logic [47:0] ox, oy, nx, ny, input logic tv_old,
                        input int ova, input int ovb);
    for (int c = 0; c <= 10; c++) begin
      frame_start = (c == 0) || (c == ova) || (c == ovb);
      if (c >= 1 && c <= 6) begin
        `CHK("mem_rd_issue", mem_rd1, 1'b1);
        `CHK("mem_addr_issue", mem_addr1, 16'(6000 + 4 * (c - 1)));
      end else begin
        `CHK("mem_rd_quiet", mem_rd1, 1'b0);
      end
      if (c == 0) `CHK("mem_addr_idle", mem_addr1, 16'd6000);
      `CHK("commit", commit1, (c == 8));
      `CHK("busy", busy1, (c >= 1 && c <= 8));
      if (c >= 1) `CHK("frame_overrun", frame_overrun1, (c == ova + 1) || (c == ovb + 1));
      `CHK("sprite_x", sprite_x1, (c >= 9) ? nx : ox);
      `CHK("sprite_y", sprite_y1, (c >= 9) ? ny : oy);
      `CHK("table_valid", table_valid1, (c >= 9) ? 1'b1 : tv_old);
      tick();
    end
    frame_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ex2, ey2;
    logic [127:0] wx_exp, wy_exp;
    logic [15:0]  wa_exp;

    for (int a = 0; a < 65536; a++) ram[a] = 16'h5A5A;
    reset        = 1'b0;
    frame_start  = 1'b0;
    frame_start2 = 1'b0;

    // 1. Reset state and quiet idle
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_sprite_x", sprite_x1, 48'd0);
    `CHK("rst_sprite_y", sprite_y1, 48'd0);
    `CHK("rst_table_valid", table_valid1, 1'b0);
    `CHK("rst_commit", commit1, 1'b0);
    `CHK("rst_overrun", frame_overrun1, 1'b0);
    `CHK("rst_busy", busy1, 1'b0);
    `CHK("rst_mem_rd", mem_rd1, 1'b0);
    `CHK("rst_mem_addr", mem_addr1, 16'd6000);
    `CHK("rst_mem_addr2", mem_addr2, 16'hFFF8);
    reset = 1'b1;
    repeat (20) tick();
    `CHK("idle_sprite_x", sprite_x1, 48'd0);
    `CHK("idle_sprite_y", sprite_y1, 48'd0);
    `CHK("idle_table_valid", table_valid1, 1'b0);
    `CHK("idle_busy", busy1, 1'b0);
    `CHK("idle_mem_rd", mem_rd1, 1'b0);
    `CHK("idle_mem_addr", mem_addr1, 16'd6000);

    // 2. First fetch
    set_table1(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60);
    fetch1(48'd0, 48'd0, {16'd50, 16'd30, 16'd10}, {16'd60, 16'd40, 16'd20},
           1'b0, -10, -10);

    // 3. Refetch with altered RAM: old values hold until the commit edge
    set_table1(16'd111, 16'd222, 16'd333, 16'd444, 16'd555, 16'd666);
    fetch1({16'd50, 16'd30, 16'd10}, {16'd60, 16'd40, 16'd20},
           {16'd555, 16'd333, 16'd111}, {16'd666, 16'd444, 16'd222}, 1'b1, -10, -10);

    // 4. Extra frame_start during ISSUE (c3) and COMMIT (c8)
    set_table1(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6);
    fetch1({16'd555, 16'd333, 16'd111}, {16'd666, 16'd444, 16'd222},
           {16'd5, 16'd3, 16'd1}, {16'd6, 16'd4, 16'd2}, 1'b1, 3, 8);

    // 5. Reset in the middle of a fetch
    set_table1(16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    `CHK("midrst_sprite_x", sprite_x1, 48'd0);
    `CHK("midrst_sprite_y", sprite_y1, 48'd0);
    `CHK("midrst_table_valid", table_valid1, 1'b0);
    `CHK("midrst_busy", busy1, 1'b0);
    `CHK("midrst_mem_rd", mem_rd1, 1'b0);
    `CHK("midrst_mem_addr", mem_addr1, 16'd6000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    `CHK("postrst_busy", busy1, 1'b0);
    `CHK("postrst_mem_rd", mem_rd1, 1'b0);
    `CHK("postrst_table_valid", table_valid1, 1'b0);
    fetch1(48'd0, 48'd0, {16'd11, 16'd9, 16'd7}, {16'd12, 16'd10, 16'd8},
           1'b0, -10, -10);

    // 6. Eight sprites, wrapping address range, latency 2
    for (int k = 0; k < 16; k++) ram[16'(16'hFFF8 + 2 * k)] = 16'(16'hA000 + k);
    for (int i = 0; i < 8; i++) begin
      ex2[i*16 +: 16] = 16'(16'hA000 + 2 * i);
      ey2[i*16 +: 16] = 16'(16'hA000 + 2 * i + 1);
    end
    for (int c = 0; c <= 20; c++) begin
      frame_start2 = (c == 0);
      wa_exp = 16'(16'hFFF8 + 2 * (c - 1));
      wx_exp = (c >= 20) ? ex2 : 128'd0;
      wy_exp = (c >= 20) ? ey2 : 128'd0;
      if (c >= 1 && c <= 16) begin
        total++;
        if (mem_rd2 === 1'b1) passed++;
        else begin
          failed++;
          $error("FAIL w_mem_rd: observed %0h expected 1", mem_rd2);
        end
        total++;
        if (mem_addr2 === wa_exp) passed++;
        else begin
          failed++;
          $error("FAIL w_mem_addr: observed %0h expected %0h", mem_addr2, wa_exp);
        end
      end else begin
        total++;
        if (mem_rd2 === 1'b0) passed++;
        else begin
          failed++;
          $error("FAIL w_mem_rd_quiet: observed %0h expected 0", mem_rd2);
        end
      end
      total++;
      if (commit2 === (c == 19)) passed++;
      else begin
        failed++;
        $error("FAIL w_commit: observed %0h expected %0h", commit2, (c == 19));
      end
      total++;
      if (sprite_x2 === wx_exp) passed++;
      else begin
        failed++;
        $error("FAIL w_sprite_x: observed %0h expected %0h", sprite_x2, wx_exp);
      end
      total++;
      if (sprite_y2 === wy_exp) passed++;
      else begin
        failed++;
        $error("FAIL w_sprite_y: observed %0h expected %0h", sprite_y2, wy_exp);
      end
      total++;
      if (table_valid2 === (c >= 20)) passed++;
      else begin
        failed++;
        $error("FAIL w_table_valid: observed %0h expected %0h", table_valid2, (c >= 20));
      end
      tick();
    end
    frame_start2 = 1'b0;
    `CHK("w_busy_end", busy2, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
